// File: rtl/seq_frame_rx.sv
// Receive-side checker for 3-symbol SOF/P1/P2 counter frames: validates payload
// thresholds, reconstructs the generator count and keeps good/error statistics.
module seq_frame_rx #(
  parameter logic [7:0] SOF     = 8'h00,
  parameter int         TH1     = 7,
  parameter int         TH2     = 20,
  parameter int         OFFSET  = 8,
  parameter int         TIMEOUT = 64
) (
  input  logic       CLK,
  input  logic       RSTX,
  input  logic [7:0] IN,
  input  logic       VALID,
  output logic [7:0] OUT,
  output logic [7:0] P1_OUT,
  output logic       FRAME_OK,
  output logic       ERR,
  output logic [1:0] ERR_CODE,
  output logic [7:0] FRAME_CNT,
  output logic [7:0] ERR_CNT
);

  localparam logic [8:0]  TH1_W      = 9'(TH1);
  localparam logic [8:0]  TH2_W      = 9'(TH2);
  localparam logic [8:0]  OFFSET_W   = 9'(OFFSET);
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_BAD_P1  = 2'd1;
  localparam logic [1:0] CODE_BAD_P2  = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GOT_SOF = 2'd1,
    GOT_P1  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  p1_reg, p1_next;
  logic [15:0] timer_reg, timer_next;
  logic [7:0]  out_reg, out_next;
  logic [7:0]  p1_out_reg, p1_out_next;
  logic        frame_ok_reg, frame_ok_next;
  logic        err_reg, err_next;
  logic [1:0]  err_code_reg, err_code_next;
  logic [7:0]  frame_cnt_reg, frame_cnt_next;
  logic [7:0]  err_cnt_reg, err_cnt_next;
  logic [8:0]  sum;

  // Ninth bit catches P2 + OFFSET overflowing the 8-bit count.
  assign sum = {1'b0, IN} + OFFSET_W;

  always_ff @(posedge CLK) begin
    if (!RSTX) begin
      state_reg     <= IDLE;
      p1_reg        <= 8'd0;
      timer_reg     <= 16'd0;
      out_reg       <= 8'd0;
      p1_out_reg    <= 8'd0;
      frame_ok_reg  <= 1'b0;
      err_reg       <= 1'b0;
      err_code_reg  <= CODE_NONE;
      frame_cnt_reg <= 8'd0;
      err_cnt_reg   <= 8'd0;
    end else begin
      state_reg     <= state_next;
      p1_reg        <= p1_next;
      timer_reg     <= timer_next;
      out_reg       <= out_next;
      p1_out_reg    <= p1_out_next;
      frame_ok_reg  <= frame_ok_next;
      err_reg       <= err_next;
      err_code_reg  <= err_code_next;
      frame_cnt_reg <= frame_cnt_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    p1_next        = p1_reg;
    timer_next     = timer_reg;
    out_next       = out_reg;
    p1_out_next    = p1_out_reg;
    frame_ok_next  = 1'b0;
    err_next       = 1'b0;
    err_code_next  = CODE_NONE;
    frame_cnt_next = frame_cnt_reg;
    err_cnt_next   = err_cnt_reg;

    case (state_reg)
      IDLE: begin
        timer_next = 16'd0;
        if (VALID && IN == SOF) begin
          state_next = GOT_SOF;
        end
      end

      GOT_SOF: begin
        if (VALID) begin
          timer_next = 16'd0;
          if (IN == SOF) begin
            state_next = GOT_SOF;
          end else if ({1'b0, IN} > TH1_W) begin
            p1_next    = IN;
            state_next = GOT_P1;
          end else begin
            err_next      = 1'b1;
            err_code_next = CODE_BAD_P1;
            state_next    = IDLE;
          end
        end else if (timer_reg == TIMER_LAST) begin
          err_next      = 1'b1;
          err_code_next = CODE_TIMEOUT;
          timer_next    = 16'd0;
          state_next    = IDLE;
        end else begin
          timer_next = timer_reg + 16'd1;
        end
      end

      GOT_P1: begin
        if (VALID) begin
          timer_next = 16'd0;
          state_next = IDLE;
          if (!sum[8] && sum > TH2_W) begin
            frame_ok_next  = 1'b1;
            out_next       = sum[7:0];
            p1_out_next    = p1_reg;
            frame_cnt_next = frame_cnt_reg + 8'd1;
          end else begin
            err_next      = 1'b1;
            err_code_next = CODE_BAD_P2;
          end
        end else if (timer_reg == TIMER_LAST) begin
          err_next      = 1'b1;
          err_code_next = CODE_TIMEOUT;
          timer_next    = 16'd0;
          state_next    = IDLE;
        end else begin
          timer_next = timer_reg + 16'd1;
        end
      end

      default: begin
        timer_next = 16'd0;
        state_next = IDLE;
      end
    endcase

    if (err_next && err_cnt_reg != 8'hFF) begin
      err_cnt_next = err_cnt_reg + 8'd1;
    end
  end

  assign OUT       = out_reg;
  assign P1_OUT    = p1_out_reg;
  assign FRAME_OK  = frame_ok_reg;
  assign ERR       = err_reg;
  assign ERR_CODE  = err_code_reg;
  assign FRAME_CNT = frame_cnt_reg;
  assign ERR_CNT   = err_cnt_reg;

endmodule

// File: tb/tb_seq_frame_rx.sv
// Directed bench for seq_frame_rx: each applied symbol pushes its expected
// registered response to a scoreboard, which is popped one cycle later.
module tb_seq_frame_rx;

  localparam int TO = 64;

  logic       CLK = 1'b0;
  logic       RSTX;
  logic [7:0] IN;
  logic       VALID;
  logic [7:0] OUT, P1_OUT, FRAME_CNT, ERR_CNT;
  logic       FRAME_OK, ERR;
  logic [1:0] ERR_CODE;

  seq_frame_rx #(.SOF(8'h00), .TH1(7), .TH2(20), .OFFSET(8), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RSTX(RSTX), .IN(IN), .VALID(VALID),
    .OUT(OUT), .P1_OUT(P1_OUT), .FRAME_OK(FRAME_OK), .ERR(ERR),
    .ERR_CODE(ERR_CODE), .FRAME_CNT(FRAME_CNT), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       ok;
    logic       er;
    logic [1:0] code;
    logic [7:0] o;
    logic [7:0] p1;
    logic [7:0] fc;
    logic [7:0] ec;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Expected persistent outputs, updated only by directed expectations
  logic [7:0] exp_out = 8'd0, exp_p1 = 8'd0, exp_fc = 8'd0, exp_ec = 8'd0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clock_and_check(input string tag);
    exp_t e;
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".frame_ok"}, {7'd0, FRAME_OK}, {7'd0, e.ok});
      chk({tag, ".err"},      {7'd0, ERR},      {7'd0, e.er});
      chk({tag, ".err_code"}, {6'd0, ERR_CODE}, {6'd0, e.code});
      chk({tag, ".out"},      OUT,              e.o);
      chk({tag, ".p1_out"},   P1_OUT,           e.p1);
      chk({tag, ".frame_cnt"}, FRAME_CNT,       e.fc);
      chk({tag, ".err_cnt"},  ERR_CNT,          e.ec);
    end
  endtask

  // v/d: stimulus; ok/er/code: expected pulse; o/p1: new OUT/P1_OUT when ok
  task automatic step(input string tag, input logic v, input logic [7:0] d,
                      input logic ok, input logic er, input logic [1:0] code,
                      input logic [7:0] o, input logic [7:0] p1);
    exp_t e;
    RSTX  = 1'b1;
    VALID = v;
    IN    = d;
    if (ok) begin
      exp_out = o;
      exp_p1  = p1;
      exp_fc  = exp_fc + 8'd1;
    end
    if (er && exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
    e = '{ok, er, code, exp_out, exp_p1, exp_fc, exp_ec};
    sb.push_back(e);
    clock_and_check(tag);
  endtask

  task automatic do_reset(input string tag, input logic [7:0] d);
    exp_t e;
    RSTX  = 1'b0;
    VALID = 1'b1;
    IN    = d;
    exp_out = 8'd0; exp_p1 = 8'd0; exp_fc = 8'd0; exp_ec = 8'd0;
    e = '{1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    sb.push_back(e);
    clock_and_check(tag);
  endtask

  task automatic sym(input string tag, input logic [7:0] d);
    step(tag, 1'b1, d, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
  endtask

  task automatic good(input string tag, input logic [7:0] d, input logic [7:0] o, input logic [7:0] p1);
    step(tag, 1'b1, d, 1'b1, 1'b0, 2'd0, o, p1);
  endtask

  task automatic bad(input string tag, input logic v, input logic [7:0] d, input logic [1:0] code);
    step(tag, v, d, 1'b0, 1'b1, code, 8'd0, 8'd0);
  endtask

  task automatic gap(input string tag);
    step(tag, 1'b0, 8'hAA, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
  endtask

  initial begin
    RSTX = 1'b0; VALID = 1'b0; IN = 8'h00;
    do_reset("rst0", 8'h00);
    do_reset("rst1", 8'h00);

    // Basic good frame
    sym("t1.sof", 8'h00);
    sym("t1.p1", 8'h09);
    good("t1.p2", 8'h0F, 8'h17, 8'h09);

    // BAD_P1 then good frame
    sym("t2.sof", 8'h00);
    bad("t2.p1", 1'b1, 8'h05, 2'd1);
    sym("t2b.sof", 8'h00);
    sym("t2b.p1", 8'h08);
    good("t2b.p2", 8'h10, 8'h18, 8'h08);

    // BAD_P2: sum equal to TH2, then sum overflow
    sym("t3.sof", 8'h00);
    sym("t3.p1", 8'h08);
    bad("t3.p2", 1'b1, 8'h0C, 2'd2);
    sym("t3b.sof", 8'h00);
    sym("t3b.p1", 8'h08);
    bad("t3b.p2", 1'b1, 8'hF8, 2'd2);

    // Timeout on the 64th idle cycle
    sym("t4.sof", 8'h00);
    sym("t4.p1", 8'h09);
    for (int i = 0; i < TO - 1; i++) gap("t4.gap");
    bad("t4.to", 1'b0, 8'h00, 2'd3);
    sym("t4.idle", 8'h09);

    // VALID on the 64th idle cycle wins over timeout
    sym("t4b.sof", 8'h00);
    sym("t4b.p1", 8'h09);
    for (int i = 0; i < TO - 1; i++) gap("t4b.gap");
    good("t4b.p2", 8'h0F, 8'h17, 8'h09);

    // Noise ignored, repeated SOF tolerated
    sym("t5.noise", 8'h33);
    sym("t5.sof", 8'h00);
    sym("t5.sof2", 8'h00);
    sym("t5.p1", 8'h09);
    good("t5.p2", 8'h0F, 8'h17, 8'h09);

    // Reset mid-frame discards it silently
    sym("t5b.sof", 8'h00);
    sym("t5b.p1", 8'h09);
    do_reset("t5b.rst", 8'h0F);
    sym("t5b.p2", 8'h0F);
    gap("t5b.after");

    // 256 back-to-back good frames wrap FRAME_CNT
    for (int i = 0; i < 256; i++) begin
      sym("t6.sof", 8'h00);
      sym("t6.p1", 8'h0A);
      good("t6.p2", 8'h20, 8'h28, 8'h0A);
    end
    chk("t6.fcnt_wrap", FRAME_CNT, 8'd0);

    // 300 BAD_P1 frames saturate ERR_CNT
    for (int i = 0; i < 300; i++) begin
      sym("t6b.sof", 8'h00);
      bad("t6b.p1", 1'b1, 8'h03, 2'd1);
    end
    chk("t6b.ecnt_sat", ERR_CNT, 8'hFF);
    chk("t6b.out_held", OUT, 8'h28);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_frame_rx.md
Name: seq_frame_rx

Overview:
- Receive-side checker for the 3-symbol counter-sequence frames that the sequence generator FSM emits on its 8-bit output.
- Hunts for the start-of-frame symbol, then validates the two payload symbols against threshold rules.
- Reconstructs the final count value and reports frame-good / error pulses plus running statistics.
- Sits at the sink end of the generator's OUT bus; the generator's OUT is wired to this block's IN, with a qualifying VALID strobe.

Parameters:
SOF, 8'h00, start-of-frame symbol value
TH1, 7, first payload symbol must be strictly greater than TH1
TH2, 20, reconstructed value (P2 + OFFSET) must be strictly greater than TH2
OFFSET, 8, added to the second payload symbol to reconstruct the generator count
TIMEOUT, 64, consecutive non-VALID cycles tolerated mid-frame (legal range 2..65535)

Ports:
CLK  input  1  clock; all logic on posedge
RSTX  input  1  reset, synchronous, active-low
IN  input  8  received symbol
VALID  input  1  IN is a symbol this cycle
OUT  output  8  last reconstructed value (P2 + OFFSET) of a good frame
P1_OUT  output  8  first payload symbol of the last good frame
FRAME_OK  output  1  one-cycle pulse per good frame
ERR  output  1  one-cycle pulse per error
ERR_CODE  output  2  0 none, 1 BAD_P1, 2 BAD_P2, 3 TIMEOUT; valid while ERR=1, 0 otherwise
FRAME_CNT  output  8  count of good frames, wraps modulo 256
ERR_CNT  output  8  count of errors, saturates at 255

Behaviour:
- Reset (RSTX=0 at posedge): state=IDLE; OUT, P1_OUT, FRAME_CNT, ERR_CNT, P1 holding register and timer = 0; FRAME_OK, ERR = 0; ERR_CODE = 0.
- Reset mid-frame: the partial frame is discarded silently; no ERR is raised.
- All outputs are registered. Response appears 1 cycle after the posedge that samples the VALID symbol.
- Symbols are consumed only when VALID=1. IN is don't-care otherwise.
- FSM states: IDLE, GOT_SOF, GOT_P1.
  - IDLE, VALID:
    - IN==SOF -> GOT_SOF.
    - Any other value is ignored; stay in IDLE with no error (resync hunt).
  - GOT_SOF, VALID:
    - IN==SOF -> stay in GOT_SOF (restart, no error).
    - Else if IN > TH1 -> latch P1, go to GOT_P1.
    - Else -> ERR, code 1, go to IDLE.
  - GOT_P1, VALID:
    - Compute sum = {1'b0,IN} + OFFSET, 9 bits wide.
    - If sum[8]==0 and sum > TH2 -> FRAME_OK, OUT <= sum[7:0], P1_OUT <= P1, FRAME_CNT += 1, go to IDLE.
    - Else (overflow or too low) -> ERR, code 2, go to IDLE.
    - IN==SOF in this state is treated as an ordinary P2 value; no special restart.
- Timer (16-bit):
  - Cleared in IDLE, on any VALID cycle, and on every state change.
  - Increments each cycle in GOT_SOF/GOT_P1 with VALID=0.
  - When the timer reaches TIMEOUT-1 and VALID=0 -> ERR, code 3, go to IDLE. The error fires on the TIMEOUT-th consecutive idle cycle.
  - A VALID arriving in that same cycle wins: the symbol is processed normally and no timeout occurs.
- ERR and FRAME_OK are mutually exclusive and never asserted in consecutive cycles for the same frame.
- ERR_CNT increments on every ERR and holds at 255.
- OUT and P1_OUT hold their values until the next good frame; errors do not modify them.
- Back-to-back frames with VALID every cycle are supported (a new SOF is accepted the cycle after a frame completes) with no dead cycle.

Test Plan:
1. Reset, then VALID symbols 0x00, 0x09, 0x0F on consecutive cycles -> FRAME_OK=1 one cycle after 0x0F; OUT=0x17, P1_OUT=0x09, FRAME_CNT=1, ERR never asserted.
2. 0x00, 0x05 -> ERR=1, ERR_CODE=1, ERR_CNT=1. Then 0x00, 0x08, 0x10 -> FRAME_OK, OUT=0x18.
3. 0x00, 0x08, 0x0C (sum 20) -> ERR code 2. Then 0x00, 0x08, 0xF8 (sum 256) -> ERR code 2; OUT unchanged from the prior good frame.
4. Timeout:
   - 0x00, 0x09, then VALID=0 for 64 cycles -> ERR code 3 on the 64th idle cycle, FSM returns to IDLE.
   - Repeat with VALID=1 (IN=0x0F) on the 64th cycle -> FRAME_OK, no ERR.
5. Noise and reset:
   - 0x33, 0x00, 0x00, 0x09, 0x0F -> 0x33 ignored, repeated SOF tolerated, one FRAME_OK.
   - Separately: 0x00, 0x09, then RSTX=0 for one cycle, then 0x0F -> all outputs 0 after reset, no FRAME_OK, no ERR.
6. Counter rollover and saturation:
   - 256 good frames back to back -> FRAME_CNT wraps to 0.
   - 300 BAD_P1 frames -> ERR_CNT stops at 255.
